onehot_seq_decoder: RTL and testbench

Registered, parametrised binary-to-one-hot decoder with sequencing modes: direct decode of a handshaked select, automatic up/down scan with programmable dwell, and single-shot timed pulse. It sits between control logic and per-channel enables (row/column select, mux strobes, channel gating). It generalises the combinational 3-to-8 decoder to SEL_W-bit selects and adds timing behaviour.

---
 rtl/onehot_seq_decoder.sv | 146 ++++++++++++++
 tb/tb_onehot_seq_decoder.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_seq_decoder.sv
// Registered binary-to-one-hot decoder with direct, scan and pulse modes.
// All outputs come from registers; sel_ready is the only combinational output.
module onehot_seq_decoder #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic [DWELL_W-1:0]    dwell,
  input  logic [SEL_W-1:0]      sel_in,
  input  logic                  sel_valid,
  output logic                  sel_ready,
  output logic [2**SEL_W-1:0]   out_onehot,
  output logic [SEL_W-1:0]      out_index,
  output logic                  busy,
  output logic                  wrap
);

  localparam int OUT_W = 2**SEL_W;

  typedef enum logic [1:0] {
    M_DIRECT = 2'b00,
    M_UP     = 2'b01,
    M_DOWN   = 2'b10,
    M_PULSE  = 2'b11
  } mode_e;

  mode_e              md;
  mode_e              mode_q;
  logic [SEL_W-1:0]   idx_q;
  logic [SEL_W-1:0]   idx_d;
  logic [DWELL_W-1:0] cnt_q;
  logic [DWELL_W-1:0] cnt_d;
  logic [DWELL_W-1:0] cnt_b;
  logic               busy_q;
  logic               busy_d;
  logic               busy_b;
  logic               wrap_q;
  logic               wrap_d;
  logic [OUT_W-1:0]   oh_q;
  logic [OUT_W-1:0]   oh_d;
  logic               chg;
  logic               acc;
  logic               due;
  logic               act;
  logic               up;

  function automatic logic [OUT_W-1:0] dec(
    input logic [SEL_W-1:0] i
  );
    logic [OUT_W-1:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  assign md  = mode_e'(mode);
  assign chg = (md != mode_q);
  assign up  = (md == M_UP);

  assign sel_ready = (md == M_PULSE) ? ~busy_q : 1'b1;
  assign acc       = sel_valid & sel_ready;

  // A mode change wipes counter and pulse before the new mode acts.
  assign cnt_b  = chg ? '0 : cnt_q;
  assign busy_b = chg ? 1'b0 : busy_q;
  assign due    = (cnt_b >= dwell);

  always_comb begin
    idx_d  = idx_q;
    cnt_d  = cnt_b;
    busy_d = busy_b;
    wrap_d = 1'b0;
    act    = 1'b0;
    unique case (md)
      M_DIRECT: begin
        if (acc) begin
          idx_d = sel_in;
          cnt_d = '0;
        end
        act = en;
      end
      M_UP, M_DOWN: begin
        if (acc) begin
          idx_d = sel_in;
          cnt_d = '0;
        end else if (en) begin
          if (due) begin
            cnt_d  = '0;
            idx_d  = up ? idx_q + 1'b1 : idx_q - 1'b1;
            wrap_d = up ? (idx_q == '1) : (idx_q == '0);
          end else begin
            cnt_d = cnt_b + 1'b1;
          end
        end
        act = en;
      end
      default: begin
        if (acc) begin
          idx_d  = sel_in;
          cnt_d  = '0;
          busy_d = 1'b1;
        end else if (busy_b && en) begin
          if (due) begin
            busy_d = 1'b0;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_b + 1'b1;
          end
        end
        act = en & busy_d;
      end
    endcase
    oh_d = act ? dec(idx_d) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= M_DIRECT;
      idx_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      wrap_q <= 1'b0;
      oh_q   <= '0;
    end else begin
      mode_q <= md;
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      wrap_q <= wrap_d;
      oh_q   <= oh_d;
    end
  end

  assign out_onehot = oh_q;
  assign out_index  = idx_q;
  assign busy       = busy_q;
  assign wrap       = wrap_q;

  a_onehot0: assert property (
    @(posedge clk) disable iff (!rst_n) $onehot0(out_onehot)
  );

endmodule

// File: tb/tb_onehot_seq_decoder.sv
// Directed bench for onehot_seq_decoder (SEL_W=3, DWELL_W=8).
// Each scenario task drives stimulus and checks outputs inline.
module tb_onehot_seq_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic [7:0] dwell;
  logic [2:0] sel_in;
  logic       sel_valid;
  logic       sel_ready;
  logic [7:0] out_onehot;
  logic [2:0] out_index;
  logic       busy;
  logic       wrap;

  int passed = 0;
  int total  = 0;

  localparam logic [7:0] DEC [8] = '{
    8'h01, 8'h02, 8'h04, 8'h08,
    8'h10, 8'h20, 8'h40, 8'h80
  };
  localparam logic [2:0] UP_IDX [9] = '{
    3'd6, 3'd6, 3'd6, 3'd7, 3'd7, 3'd7, 3'd0, 3'd0, 3'd0
  };
  localparam logic UP_WRAP [9] = '{
    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0
  };
  localparam logic [2:0] DN_IDX [4] = '{3'd1, 3'd0, 3'd7, 3'd6};
  localparam logic DN_WRAP [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  onehot_seq_decoder #(.SEL_W(3), .DWELL_W(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .mode(mode),
    .dwell(dwell),
    .sel_in(sel_in),
    .sel_valid(sel_valid),
    .sel_ready(sel_ready),
    .out_onehot(out_onehot),
    .out_index(out_index),
    .busy(busy),
    .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b1;
    mode = 2'b00;
    dwell = 8'd0;
    sel_in = 3'd0;
    sel_valid = 1'b0;
    #2;
    total++;
    if (out_onehot !== 8'h00 || out_index !== 3'd0 ||
        busy !== 1'b0 || wrap !== 1'b0)
      $display("FAIL reset_state oh=%h idx=%0d busy=%b wrap=%b exp 00/0/0/0",
               out_onehot, out_index, busy, wrap);
    else passed++;
    total++;
    if (sel_ready !== 1'b1)
      $display("FAIL reset_ready got=%b exp=1", sel_ready);
    else passed++;
    #10 rst_n = 1'b1;
    tick();
    total++;
    if (out_onehot !== 8'h01 || out_index !== 3'd0)
      $display("FAIL first_edge oh=%h idx=%0d exp 01/0", out_onehot, out_index);
    else passed++;
  endtask

  task automatic test_direct();
    for (int i = 0; i < 8; i++) begin
      sel_in = 3'(i);
      sel_valid = 1'b1;
      tick();
      total++;
      if (out_onehot !== DEC[i] || out_index !== 3'(i))
        $display("FAIL direct_%0d oh=%h idx=%0d exp %h/%0d",
                 i, out_onehot, out_index, DEC[i], i);
      else passed++;
    end
    sel_valid = 1'b0;
    en = 1'b0;
    tick();
    total++;
    if (out_onehot !== 8'h00)
      $display("FAIL direct_en_low oh=%h exp=00", out_onehot);
    else passed++;
    en = 1'b1;
    tick();
    total++;
    if (out_onehot !== 8'h80 || out_index !== 3'd7)
      $display("FAIL direct_en_rise oh=%h idx=%0d exp 80/7", out_onehot, out_index);
    else passed++;
  endtask

  task automatic test_scan();
    mode = 2'b01;
    dwell = 8'd2;
    sel_in = 3'd6;
    sel_valid = 1'b1;
    for (int j = 0; j < 9; j++) begin
      tick();
      sel_valid = 1'b0;
      total++;
      if (out_index !== UP_IDX[j] || wrap !== UP_WRAP[j] ||
          out_onehot !== DEC[UP_IDX[j]])
        $display("FAIL scan_up_%0d idx=%0d wrap=%b oh=%h exp %0d/%b",
                 j, out_index, wrap, out_onehot, UP_IDX[j], UP_WRAP[j]);
      else passed++;
    end
    mode = 2'b10;
    dwell = 8'd0;
    sel_in = 3'd1;
    sel_valid = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tick();
      sel_valid = 1'b0;
      total++;
      if (out_index !== DN_IDX[j] || wrap !== DN_WRAP[j])
        $display("FAIL scan_dn_%0d idx=%0d wrap=%b exp %0d/%b",
                 j, out_index, wrap, DN_IDX[j], DN_WRAP[j]);
      else passed++;
    end
  endtask

  task automatic test_collision();
    mode = 2'b01;
    dwell = 8'd1;
    sel_in = 3'd7;
    sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
    tick();
    sel_in = 3'd3;
    sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
    total++;
    if (out_index !== 3'd3 || wrap !== 1'b0 || out_onehot !== 8'h08)
      $display("FAIL collide_load idx=%0d wrap=%b oh=%h exp 3/0/08",
               out_index, wrap, out_onehot);
    else passed++;
    tick();
    total++;
    if (out_index !== 3'd3)
      $display("FAIL collide_cnt_clr idx=%0d exp=3", out_index);
    else passed++;
    tick();
    total++;
    if (out_index !== 3'd4 || wrap !== 1'b0)
      $display("FAIL collide_step idx=%0d wrap=%b exp 4/0", out_index, wrap);
    else passed++;
    en = 1'b0;
    tick();
    tick();
    total++;
    if (out_index !== 3'd4 || out_onehot !== 8'h00)
      $display("FAIL scan_freeze idx=%0d oh=%h exp 4/00", out_index, out_onehot);
    else passed++;
    en = 1'b1;
  endtask

  task automatic test_pulse();
    mode = 2'b11;
    dwell = 8'd4;
    sel_in = 3'd5;
    sel_valid = 1'b1;
    tick();
    sel_in = 3'd2;
    for (int k = 0; k < 5; k++) begin
      total++;
      if (out_onehot !== 8'h20 || busy !== 1'b1 || sel_ready !== 1'b0)
        $display("FAIL pulse_on_%0d oh=%h busy=%b rdy=%b exp 20/1/0",
                 k, out_onehot, busy, sel_ready);
      else passed++;
      tick();
    end
    total++;
    if (out_onehot !== 8'h00 || busy !== 1'b0 ||
        sel_ready !== 1'b1 || out_index !== 3'd5)
      $display("FAIL pulse_end oh=%h busy=%b rdy=%b idx=%0d exp 00/0/1/5",
               out_onehot, busy, sel_ready, out_index);
    else passed++;
    tick();
    sel_valid = 1'b0;
    total++;
    if (out_onehot !== 8'h04 || out_index !== 3'd2 || busy !== 1'b1)
      $display("FAIL pulse_second oh=%h idx=%0d busy=%b exp 04/2/1",
               out_onehot, out_index, busy);
    else passed++;
    repeat (5) tick();
    total++;
    if (busy !== 1'b0 || out_onehot !== 8'h00)
      $display("FAIL pulse_second_end busy=%b oh=%h exp 0/00", busy, out_onehot);
    else passed++;
  endtask

  task automatic test_pulse_interrupt();
    int on_cnt;
    sel_in = 3'd1;
    sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
    on_cnt = (out_onehot != 8'h00) ? 1 : 0;
    for (int q = 1; q <= 10; q++) begin
      en = !(q >= 3 && q <= 5);
      tick();
      if (out_onehot != 8'h00) on_cnt++;
      if (q == 4) begin
        total++;
        if (out_onehot !== 8'h00 || busy !== 1'b1)
          $display("FAIL pulse_en_low oh=%h busy=%b exp 00/1", out_onehot, busy);
        else passed++;
      end
    end
    en = 1'b1;
    total++;
    if (on_cnt != 5 || busy !== 1'b0)
      $display("FAIL pulse_en_total cycles=%0d busy=%b exp 5/0", on_cnt, busy);
    else passed++;
    sel_in = 3'd3;
    sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
    tick();
    total++;
    if (busy !== 1'b1)
      $display("FAIL pulse_pre_abort busy=%b exp=1", busy);
    else passed++;
    mode = 2'b00;
    tick();
    total++;
    if (busy !== 1'b0 || out_index !== 3'd3 || out_onehot !== 8'h08)
      $display("FAIL pulse_abort busy=%b idx=%0d oh=%h exp 0/3/08",
               busy, out_index, out_onehot);
    else passed++;
  endtask

  task automatic test_async_reset();
    mode = 2'b01;
    dwell = 8'd3;
    sel_in = 3'd4;
    sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
    total++;
    if (out_index !== 3'd4 || out_onehot !== 8'h10)
      $display("FAIL pre_reset idx=%0d oh=%h exp 4/10", out_index, out_onehot);
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (out_onehot !== 8'h00 || out_index !== 3'd0 ||
        busy !== 1'b0 || wrap !== 1'b0)
      $display("FAIL async_reset oh=%h idx=%0d busy=%b wrap=%b exp 00/0/0/0",
               out_onehot, out_index, busy, wrap);
    else passed++;
    repeat (2) @(negedge clk);
    dwell = 8'd0;
    en = 1'b1;
    rst_n = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      tick();
      total++;
      if (out_index !== 3'(j) || out_onehot !== DEC[j])
        $display("FAIL post_reset_%0d idx=%0d oh=%h exp %0d/%h",
                 j, out_index, out_onehot, j, DEC[j]);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_scan();
    test_collision();
    test_pulse();
    test_pulse_interrupt();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
